pio_in_edge_irq: RTL

- Parametrised Avalon-MM slave input port, WIDTH bits wide, for camera/control status lines such as start, done and frame-valid.
- Adds the following to a plain level-read input port:
  - two-flop input synchroniser
  - per-bit edge capture register
  - interrupt mask register
  - level-sensitive irq output to the Nios II interrupt controller.
- Sits between external/asynchronous signals and the system interconnect.

---
 rtl/pio_in_pkg.sv | 21 ++
 rtl/pio_in_debounce.sv | 35 +++
 rtl/pio_in_edge_irq.sv | 113 +++++++++++
 3 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants for the edge-capturing Avalon-MM input port.
// Covers the register map, the edge-mode encodings and the warm-up length.
package pio_in_pkg;

    typedef logic [1:0] addr_t;

    localparam addr_t ADDR_DATA = 2'd0;
    localparam addr_t ADDR_RSVD = 2'd1;
    localparam addr_t ADDR_MASK = 2'd2;
    localparam addr_t ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Edges are suppressed until the warm-up counter reaches this value
    localparam logic [1:0] WARMUP_CYCLES = 2'd3;

    localparam int unsigned DEBOUNCE_CNT_W = 16;

endpackage

// File: rtl/pio_in_debounce.sv
// Per-bit debounce filter: an output bit follows its input only after the input
// has disagreed with it for CYCLES consecutive clocks.
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [DEBOUNCE_CNT_W-1:0] LAST = DEBOUNCE_CNT_W'(CYCLES - 1);

    logic [DEBOUNCE_CNT_W-1:0] cnt_q [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q[i] <= '0;
                dout[i]  <= 1'b0;
            end else if (din[i] == dout[i]) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] == LAST) begin
                dout[i]  <= din[i];
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input port with two-flop synchroniser, per-bit edge capture, irq mask and level irq.
// Define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module pio_in_edge_irq
    import pio_in_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_IRQ_MASK  = '0,
    parameter int unsigned      DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] evt_raw;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [1:0]       warm_q;
    logic             wr_en;
    logic [31:0]      rd_d;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    pio_in_debounce #(
        .WIDTH  (WIDTH),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (sync2_q),
        .dout  (data)
    );
`else
    localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign data = sync2_q;
`endif

    always_comb begin
        evt_raw = data & ~prev_q;
        case (EDGE_TYPE)
            EDGE_FALL: evt_raw = ~data & prev_q;
            EDGE_ANY:  evt_raw = data ^ prev_q;
            default:   evt_raw = data & ~prev_q;
        endcase
    end

    // Reset values of prev/data would otherwise look like edges right after reset
    assign evt = (warm_q == WARMUP_CYCLES) ? evt_raw : '0;

    assign wr_en  = chipselect & ~write_n;
    assign clr    = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    // A new event beats a simultaneous clear of the same bit
    assign edge_d = evt | (edge_q & ~clr);

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA: rd_d[WIDTH-1:0] = data;
            ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_d[WIDTH-1:0] = edge_q;
            default:   rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= '0;
            edge_q   <= '0;
            mask_q   <= RESET_IRQ_MASK;
            warm_q   <= '0;
            readdata <= '0;
        end else begin
            prev_q   <= data;
            edge_q   <= edge_d;
            readdata <= rd_d;
            if (warm_q != WARMUP_CYCLES) begin
                warm_q <= warm_q + 2'd1;
            end
            if (wr_en && address == ADDR_MASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_q & mask_q);

endmodule
